// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and helpers for the clk_div_ctrl shared divider.
// Optional ownership timeout is enabled by CLK_DIV_CTRL_TIMEOUT_EN.
package clk_div_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 26;
   localparam int MAXN      = 8;
   localparam int MAXW      = 64;

   // Divisors are padded to a fixed lane width so one helper fits any WIDTH.
   function automatic logic [MAXW-1:0] div_slice(
      input logic [MAXN*MAXW-1:0] v,
      input int unsigned          i
   );
      return v[i*MAXW +: MAXW];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: pointer register plus a combinational pick
// that searches from the pointer and wraps.
module rr_arbiter
   import clk_div_ctrl_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic            clk_in,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            adv,
   input  logic [IW-1:0]   adv_idx,
   output logic            valid,
   output logic [IW-1:0]   win,
   output logic [NREQ-1:0] onehot
);

   logic [IW-1:0] ptr;

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (adv) begin
         ptr <= (adv_idx == IW'(NREQ-1)) ? '0 : adv_idx + IW'(1);
      end
   end

   always_comb begin
      valid  = 1'b0;
      win    = '0;
      onehot = '0;
      for (int k = 0; k < NREQ; k++) begin
         int unsigned j;
         j = (32'(ptr) + 32'(k)) % NREQ;
         if (!valid && req[j]) begin
            valid = 1'b1;
            win   = IW'(j);
         end
      end
      if (valid) onehot[win] = 1'b1;
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Shared runtime-programmable clock divider with round-robin ownership.
// Define CLK_DIV_CTRL_TIMEOUT_EN to bound ownership to MAX_PERIODS periods.
module clk_div_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int NREQ        = DEF_NREQ,
   parameter int WIDTH       = DEF_WIDTH,
   parameter int MAX_PERIODS = 16
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              en,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*WIDTH-1:0] div_val,
   output logic [NREQ-1:0]   gnt,
   output logic              ack,
   output logic              err,
   output logic              clk_out,
   output logic              tick,
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
   output logic              timeout,
`endif
   output logic              busy
);

   localparam int IW = $clog2(NREQ);

   state_t            state;
   logic [WIDTH-1:0]  cnt;
   logic [WIDTH-1:0]  div_reg;
   logic [WIDTH-1:0]  div_sel;
   logic [IW-1:0]     own;
   logic [IW-1:0]     win;
   logic              valid;
   logic              adv;
   logic              hit;
   logic              own_req;
   logic [NREQ-1:0]   onehot;
   logic [NREQ-1:0]   req_arb;
   logic [MAXN*MAXW-1:0] div_pad;
   logic [MAXW-1:0]   sel_w;
   logic              unused_sel;

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
   localparam int PW = $clog2(MAX_PERIODS+1);
   logic [PW-1:0]     pcnt;
   logic [NREQ-1:0]   lock;
   assign req_arb = req & ~lock;
`else
   assign req_arb = req;
`endif

   always_comb begin
      div_pad = '0;
      for (int i = 0; i < NREQ; i++) begin
         div_pad[i*MAXW +: WIDTH] = div_val[i*WIDTH +: WIDTH];
      end
   end

   assign sel_w      = div_slice(div_pad, 32'(win));
   assign div_sel    = sel_w[WIDTH-1:0];
   assign unused_sel = ^sel_w;

   assign adv     = (state == IDLE) && valid;
   assign hit     = en && (cnt == div_reg - WIDTH'(1));
   assign own_req = req[own];
   assign busy    = (state != IDLE);

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .clk_in  (clk_in),
      .rst     (rst),
      .req     (req_arb),
      .adv     (adv),
      .adv_idx (win),
      .valid   (valid),
      .win     (win),
      .onehot  (onehot)
   );

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         gnt     <= '0;
         ack     <= 1'b0;
         err     <= 1'b0;
         tick    <= 1'b0;
         clk_out <= 1'b0;
         cnt     <= '0;
         div_reg <= '0;
         own     <= '0;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
         timeout <= 1'b0;
         pcnt    <= '0;
         lock    <= '0;
`endif
      end else begin
         ack  <= 1'b0;
         err  <= 1'b0;
         tick <= 1'b0;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
         timeout <= 1'b0;
         lock    <= lock & req;
`endif
         unique case (state)
            IDLE: begin
               cnt     <= '0;
               clk_out <= 1'b0;
               if (valid) begin
                  if (div_sel != '0) begin
                     gnt     <= onehot;
                     div_reg <= div_sel;
                     own     <= win;
                     ack     <= 1'b1;
                     state   <= RUN;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
                     pcnt    <= '0;
`endif
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            RUN, DRAIN: begin
               if (hit) begin
                  cnt     <= '0;
                  clk_out <= ~clk_out;
                  tick    <= 1'b1;
               end else if (en) begin
                  cnt <= cnt + WIDTH'(1);
               end
               if (state == DRAIN) begin
                  if (hit && clk_out) begin
                     state <= IDLE;
                     gnt   <= '0;
                  end
               end else if (hit) begin
                  // A toggle wins; release is re-evaluated on the new values.
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
                  if (clk_out) begin
                     if (pcnt == PW'(MAX_PERIODS-1)) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        timeout   <= 1'b1;
                        lock[own] <= 1'b1;
                     end else begin
                        pcnt <= pcnt + PW'(1);
                     end
                  end
`endif
               end else if (!own_req) begin
                  if (!clk_out && cnt == '0) begin
                     state <= IDLE;
                     gnt   <= '0;
                     cnt   <= '0;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl (NREQ=4, WIDTH=8).
// Timeout checks are built when CLK_DIV_CTRL_TIMEOUT_EN is defined.
module tb_clk_div_ctrl;

   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam int MP   = 2;

   logic        clk_in = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] div_val = '0;
   logic [3:0]  gnt;
   logic        ack, err, clk_out, tick, busy;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
   logic        timeout;
`endif

   always #5 clk_in = ~clk_in;

   clk_div_ctrl #(
      .NREQ        (NREQ),
      .WIDTH       (W),
      .MAX_PERIODS (MP)
   ) dut (
      .clk_in  (clk_in),
      .rst     (rst),
      .en      (en),
      .req     (req),
      .div_val (div_val),
      .gnt     (gnt),
      .ack     (ack),
      .err     (err),
      .clk_out (clk_out),
      .tick    (tick),
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
      .timeout (timeout),
`endif
      .busy    (busy)
   );

   typedef struct {
      logic [3:0]  req;
      logic [31:0] div;
      logic [3:0]  gnt;
      int          half;
   } vec_t;

   vec_t vt[6];
   int   checks = 0;
   int   errors = 0;
   int   exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      while (!ack && n < 20) begin
         step();
         n++;
      end
      chk("ack_seen", 32'(ack), 1);
   endtask

   // Counts cycles to each tick and scores them against queued intervals.
   task automatic run_ticks(input int ntog, input int half,
                            input logic start);
      int cyc;
      int got;
      int e;
      for (int t = 0; t < ntog; t++) exp_q.push_back(half);
      cyc = 0;
      got = 0;
      while (got < ntog && cyc < 200) begin
         step();
         cyc++;
         if (tick) begin
            got++;
            e = exp_q.pop_front();
            chk("tick_interval", 32'(cyc), 32'(e));
            chk("clk_level", 32'(clk_out), 32'((got % 2) ^ start));
            cyc = 0;
         end
      end
      chk("tick_count", 32'(got), 32'(ntog));
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      vt[0] = '{4'b0001, 32'h0000_0003, 4'b0001, 3};
      vt[1] = '{4'b0101, 32'h0005_0002, 4'b0100, 5};
      vt[2] = '{4'b0011, 32'h0000_0204, 4'b0001, 4};
      vt[3] = '{4'b1010, 32'h0700_0600, 4'b0010, 6};
      vt[4] = '{4'b1010, 32'h0700_0600, 4'b1000, 7};
      vt[5] = '{4'b1111, 32'h0202_0202, 4'b0001, 2};

      step();
      step();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_clk", 32'(clk_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pulses", 32'({ack, err, tick}), 0);
      rst = 1'b1;
      en  = 1'b1;
      step();
      step();
      chk("idle_gnt", 32'(gnt), 0);
      chk("idle_pulses", 32'({ack, err, tick}), 0);

      for (int i = 0; i < 6; i++) begin
         div_val = vt[i].div;
         req     = vt[i].req;
         wait_ack(n);
         chk("grant_lat", 32'(n), 1);
         chk("grant_gnt", 32'(gnt), 32'(vt[i].gnt));
         chk("grant_busy", 32'(busy), 1);
         run_ticks(4, vt[i].half, 1'b0);
         req = '0;
         step();
         chk("bound_gnt", 32'(gnt), 0);
         chk("bound_busy", 32'(busy), 0);
      end

      req     = 4'b0010;
      div_val = 32'h0000_0004;
      step();
      chk("zero_err", 32'(err), 1);
      chk("zero_gnt", 32'(gnt), 0);
      chk("zero_busy", 32'(busy), 0);
      req = 4'b0011;
      step();
      chk("after_err_ack", 32'(ack), 1);
      chk("after_err_gnt", 32'(gnt), 32'b0001);
      chk("err_pulse_end", 32'(err), 0);

      run_ticks(1, 4, 1'b0);
      step();
      step();
      en = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (k == 3) req = '0;
         step();
         chk("frz_tick", 32'(tick), 0);
         chk("frz_clk", 32'(clk_out), 1);
      end
      chk("drain_gnt", 32'(gnt), 32'b0001);
      chk("drain_busy", 32'(busy), 1);
      req     = 4'b0100;
      div_val = 32'h0003_0004;
      en      = 1'b1;
      run_ticks(1, 2, 1'b1);
      chk("drain_end_gnt", 32'(gnt), 0);
      chk("drain_end_busy", 32'(busy), 0);
      step();
      chk("handover_gnt", 32'(gnt), 32'b0100);
      chk("handover_ack", 32'(ack), 1);

      for (int k = 0; k < 4; k++) step();
      chk("pre_rst_clk", 32'(clk_out), 1);
      #3;
      rst = 1'b0;
      #1;
      chk("async_gnt", 32'(gnt), 0);
      chk("async_clk", 32'(clk_out), 0);
      chk("async_busy", 32'(busy), 0);
      chk("async_pulses", 32'({ack, err, tick}), 0);
      req = '0;
      step();
      step();
      rst = 1'b1;
      step();

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
      req     = 4'b0001;
      div_val = 32'h0000_0001;
      wait_ack(n);
      chk("to_gnt", 32'(gnt), 32'b0001);
      n = 0;
      while (!timeout && n < 20) begin
         step();
         n++;
      end
      chk("to_cycles", 32'(n), 4);
      chk("to_gnt_off", 32'(gnt), 0);
      chk("to_clk", 32'(clk_out), 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("to_locked_gnt", 32'(gnt), 0);
         chk("to_locked_ack", 32'(ack), 0);
      end
      req = '0;
      step();
      req = 4'b0001;
      step();
      chk("to_regrant", 32'(gnt), 32'b0001);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
